// File: rtl/ula_mult_div.sv
// rtl/ula_mult_div.sv - iterative multiply/divide unit with HI/LO registers
module ula_mult_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic                 is_div;
    logic                 neg_lo;
    logic                 neg_hi;
    logic                 div0;
    logic [WIDTH-1:0]     opnd_q;
    logic [WIDTH-1:0]     rs_q;
    logic [2*WIDTH-1:0]   acc;

    // operand preparation: magnitudes for signed ops (op[0]=0)
    logic                 signed_op;
    logic [WIDTH-1:0]     rs_mag;
    logic [WIDTH-1:0]     rt_mag;
    assign signed_op = ~op[0];
    assign rs_mag    = (signed_op && rs[WIDTH-1]) ? -rs : rs;
    assign rt_mag    = (signed_op && rt[WIDTH-1]) ? -rt : rt;

    logic last_step;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    // one iteration: shift-add for multiply, restoring shift-subtract for divide
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   acc_step;
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        div_diff = rem_sh - {1'b0, opnd_q};
        acc_step = acc;
        if (!is_div) begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // final sign correction and divide-by-zero override
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     hi_fix;
    logic [WIDTH-1:0]     lo_fix;
    always_comb begin
        prod_fix = neg_lo ? -acc : acc;
        hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
        lo_fix   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div0) begin
                lo_fix = '1;
                hi_fix = rs_q;
            end else begin
                lo_fix = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                hi_fix = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_step) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // operand capture and iteration datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            div0   <= 1'b0;
            opnd_q <= '0;
            rs_q   <= '0;
            acc    <= '0;
        end else if (state == IDLE && start) begin
            cnt    <= '0;
            is_div <= op[1];
            neg_lo <= signed_op & (rs[WIDTH-1] ^ rt[WIDTH-1]);
            neg_hi <= signed_op & rs[WIDTH-1];
            div0   <= op[1] & (rt == '0);
            opnd_q <= op[1] ? rt_mag : rs_mag;
            rs_q   <= rs;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
        end else if (state == CALC) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
        end
    end

    // architectural HI/LO, busy and done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
            if (state == IDLE && start) begin
                busy <= 1'b1;
            end else if (state == FIX) begin
                hi   <= hi_fix;
                lo   <= lo_fix;
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ula_mult_div.sv
// tb/tb_ula_mult_div.sv - scoreboard bench for ula_mult_div
module tb_ula_mult_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    ula_mult_div #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    typedef struct packed {
        logic [31:0] h;
        logic [31:0] l;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa;
        longint      sbv;
        sa  = longint'(int'(a));
        sbv = longint'(int'(b));
        case (o)
            2'b00: begin
                p = 64'(sa * sbv);
                e = {p[63:32], p[31:0]};
            end
            2'b01: begin
                p = {32'h0, a} * {32'h0, b};
                e = {p[63:32], p[31:0]};
            end
            2'b10: begin
                if (b == 32'h0) e = {a, 32'hFFFF_FFFF};
                else begin
                    p    = 64'(sa % sbv);
                    e.h  = p[31:0];
                    p    = 64'(sa / sbv);
                    e.l  = p[31:0];
                end
            end
            default: begin
                if (b == 32'h0) e = {a, 32'hFFFF_FFFF};
                else            e = {a % b, a / b};
            end
        endcase
        return e;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        rs    = a;
        rt    = b;
        start = 1'b1;
        sb.push_back(model(o, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // waits for done; if inject>0, drives a bogus start and mthi at that cycle
    task automatic wait_done(input int inject);
        int   n;
        exp_t e;
        n = 0;
        while (1) begin
            @(posedge clk);
            #1;
            n++;
            if (n == inject) begin
                start = 1'b1;
                op    = 2'b11;
                rs    = 32'h5555_0000;
                rt    = 32'h3;
                hi_we = 1'b1;
                wdata = 32'h0000_1234;
            end else if (inject > 0 && n == inject + 1) begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            if (done || n >= 100) break;
        end
        check("latency", 64'(n), 64'd33);
        check("busy_at_done", 64'(busy), 64'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("hi", 64'(hi), 64'(e.h));
            check("lo", 64'(lo), 64'(e.l));
        end else begin
            check("sb_empty", 64'd1, 64'd0);
        end
    endtask

    initial begin
        int dcnt;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        rs    = '0;
        rt    = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(2'b00, 32'd7, 32'hFFFF_FFFD);
        wait_done(0);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0);
        issue(2'b10, 32'd100, 32'd7);
        wait_done(0);

        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0);

        issue(2'b11, 32'd100, 32'd0);
        wait_done(0);
        @(posedge clk);
        #1;
        check("done_pulse", 64'(done), 64'd0);

        issue(2'b00, 32'd12345, 32'hFFFF_FFFA);
        wait_done(5);

        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthi", 64'(hi), 64'hAAAA_5555);
        check("mtlo", 64'(lo), 64'hAAAA_5555);
        @(posedge clk);
        #1;
        check("hold_hi", 64'(hi), 64'hAAAA_5555);

        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        dcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check("aborted_no_done", 64'(dcnt), 64'd0);

        issue(2'b11, 32'hDEAD_BEEF, 32'h0000_1000);
        wait_done(0);

        for (int i = 0; i < 6; i++) begin
            issue(2'($urandom_range(0, 3)), $urandom, (i == 5) ? 32'h0 : $urandom);
            wait_done(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
